mem_bus_decoder: RTL and testbench

//  Parametrised one-master / N-slave bus decoder for the core's mem_valid/mem_ready bus.

---
 rtl/mem_bus_decoder.sv | 155 +++++++++++++++
 tb/tb_mem_bus_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
// One-master / N-slave decoder for the mem_valid/mem_ready bus: address-window routing,
// registered slave select, unmapped/timeout error response and error capture registers.
module mem_bus_decoder #(
    parameter int                      N_SLAVES   = 3,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {32'h03000000, 32'h00000000, 32'h00050000},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {3{32'hFFFF0000}},
    parameter int                      TIMEOUT    = 255,
    parameter logic [31:0]             ERR_RDATA  = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [31:0]              m_addr,
    output logic [31:0]              m_rdata,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [N_SLAVES-1:0]      s_valid,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [N_SLAVES*32-1:0]   s_rdata,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    // ST_UNMAPPED is the settle cycle that places the unmapped error response two cycles after m_valid
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_UNMAPPED = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   sel_r;
    logic [TMR_W-1:0]   timer_r;
    logic               hit_s;
    logic [SEL_W-1:0]   hit_idx_s;
    logic               sel_ready_s;
    logic [31:0]        sel_rdata_s;

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    // Address decode: scan from the top index down so the lowest matching window wins
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            hit_idx_s = ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) ? SEL_W'(i) : hit_idx_s;
            hit_s     = hit_s | ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
        end
    end

    // Return-path mux of the registered selected slave
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = 32'h00000000;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_ready_s = (sel_r == SEL_W'(i)) ? s_ready[i] : sel_ready_s;
            sel_rdata_s = (sel_r == SEL_W'(i)) ? s_rdata[32*i +: 32] : sel_rdata_s;
        end
    end

    // Master and slave handshake outputs, decoded from the registered state
    always_comb begin
        s_valid = '0;
        m_ready = 1'b0;
        m_rdata = 32'h00000000;
        bus_err = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    s_valid[i] = (sel_r == SEL_W'(i)) & m_valid;
                end
                // a master that withdrew its request never sees a completion
                m_ready = m_valid & sel_ready_s;
                m_rdata = sel_rdata_s;
            end
            ST_ERROR: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
                bus_err = 1'b1;
            end
            default: begin
                s_valid = '0;
                m_ready = 1'b0;
                m_rdata = 32'h00000000;
                bus_err = 1'b0;
            end
        endcase
    end

    // Transfer sequencing, access timer and error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sel_r     <= '0;
            timer_r   <= '0;
            err_addr  <= 32'h00000000;
            err_count <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (hit_s) begin
                            sel_r   <= hit_idx_s;
                            timer_r <= '0;
                            state_r <= ST_ACCESS;
                        end else begin
                            state_r <= ST_UNMAPPED;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    timer_r <= timer_r + TMR_W'(1);
                    // completion outranks a timeout landing in the same cycle
                    if (!m_valid || sel_ready_s) begin
                        state_r <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (timer_r == TMR_LIMIT)) begin
                        state_r <= ST_ERROR;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_UNMAPPED: begin
                    state_r <= m_valid ? ST_ERROR : ST_IDLE;
                end
                ST_ERROR: begin
                    err_addr <= m_addr;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end else begin
                        err_count <= err_count;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Randomized self-checking bench for mem_bus_decoder: transaction-level reference model of
// address windows, latency, timeout and error capture.
module tb_mem_bus_decoder;

    localparam int NS  = 3;
    localparam int TMO = 4;
    // slave1 window (0x00000000-0x00FFFFFF) overlaps slave0 (0x0005xxxx): slave0 must win there
    localparam logic [NS*32-1:0] BASE = {32'h03000000, 32'h00000000, 32'h00050000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF0000, 32'hFF000000, 32'hFFFF0000};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m_valid = 1'b0;
    logic              m_ready;
    logic [31:0]       m_addr = 32'h0;
    logic [31:0]       m_rdata;
    logic [31:0]       m_wdata = 32'h0;
    logic [3:0]        m_wstrb = 4'h0;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready = '0;
    logic [NS*32-1:0]  s_rdata = '0;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;

    int                n_checks = 0;
    int                n_errors = 0;
    int                err_cnt_m = 0;
    logic [31:0]       err_addr_m = 32'h0;

    mem_bus_decoder #(
        .N_SLAVES   (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TMO),
        .ERR_RDATA  (32'h00000000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_rdata   (m_rdata),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Target slave from the address windows as ranges, lowest index first; -1 = unmapped
    function automatic int ref_target(input logic [31:0] a);
        if (a >= 32'h00050000 && a <= 32'h0005FFFF) return 0;
        if (a <= 32'h00FFFFFF) return 1;
        if (a >= 32'h03000000 && a <= 32'h0300FFFF) return 2;
        return -1;
    endfunction

    // One transfer starting at a negedge (its IDLE cycle); returns at the negedge after m_ready.
    // lat = ACCESS cycles before the selected slave raises s_ready (large = never).
    task automatic run_txn(input logic [31:0] addr, input int lat);
        int            tgt;
        int            done;
        bit            err;
        logic [NS-1:0] sv_exp;
        tgt = ref_target(addr);
        if (tgt < 0) begin
            done = 2; err = 1'b1;
        end else if (lat <= TMO) begin
            done = 1 + lat; err = 1'b0;
        end else begin
            done = TMO + 2; err = 1'b1;
        end
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = $urandom;
        m_wstrb = 4'($urandom_range(0, 15));
        s_ready = '0;
        s_rdata = {$urandom, $urandom, $urandom};
        #1;
        check_val("idle_m_ready", m_ready, 1'b0);
        check_val("idle_s_valid", s_valid, '0);
        check_val("err_count", err_count, err_cnt_m[7:0]);
        check_val("err_addr", err_addr, err_addr_m);
        for (int k = 1; k <= done; k++) begin
            @(negedge clk);
            s_ready = NS'($urandom);
            if (tgt >= 0) s_ready[tgt] = (k - 1 == lat);
            #1;
            sv_exp = '0;
            if (tgt >= 0 && !(err && k == done)) sv_exp[tgt] = 1'b1;
            check_val("s_valid", s_valid, sv_exp);
            check_val("m_ready", m_ready, k == done);
            check_val("bus_err", bus_err, err && k == done);
            if (k == 1) begin
                check_val("s_addr", s_addr, addr);
                check_val("s_wdata", s_wdata, m_wdata);
                check_val("s_wstrb", s_wstrb, m_wstrb);
            end
            if (k == done) check_val("m_rdata", m_rdata, err ? 32'h0 : s_rdata[32*tgt +: 32]);
        end
        if (err) begin
            err_cnt_m  = (err_cnt_m == 255) ? 255 : err_cnt_m + 1;
            err_addr_m = addr;
        end
        @(negedge clk);
        s_ready = '0;
    endtask

    task automatic idle_gap();
        m_valid = 1'b0;
        #1;
        check_val("gap_m_ready", m_ready, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_m_ready", m_ready, 1'b0);
        check_val("rst_m_rdata", m_rdata, 32'h0);
        check_val("rst_s_valid", s_valid, '0);
        check_val("rst_bus_err", bus_err, 1'b0);
        check_val("rst_err_addr", err_addr, 32'h0);
        check_val("rst_err_count", err_count, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h00050010, 1);   // slave0 read
        run_txn(32'h00000004, 2);   // slave1 write, back-to-back
        idle_gap();
        run_txn(32'h01000000, 0);   // unmapped
        run_txn(32'h03000000, 99);  // slave2 never ready: timeout
        run_txn(32'h00050020, 0);   // overlap resolves to slave0
        run_txn(32'h03000040, TMO); // ready on the last allowed cycle still completes
        idle_gap();

        // master withdraws mid-access: no m_ready, no error
        m_valid = 1'b1; m_addr = 32'h00000100; s_ready = '0;
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        check_val("drop_s_valid", s_valid, '0);
        check_val("drop_m_ready", m_ready, 1'b0);
        @(negedge clk);
        #1;
        check_val("drop_idle_ready", m_ready, 1'b0);
        check_val("drop_idle_err", bus_err, 1'b0);
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h00050000 | ($urandom & 32'h0000FFFC);
                1:       a = $urandom & 32'h00FFFFFC;
                2:       a = 32'h03000000 | ($urandom & 32'h0000FFFC);
                default: a = $urandom;
            endcase
            run_txn(a, $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) idle_gap();
        end

        for (int n = 0; n < 300; n++) begin
            run_txn(32'h01000000 | ($urandom & 32'h00FFFFFC), 0);
        end
        check_val("sat_err_count", err_count, 8'hFF);

        // synchronous reset in the middle of an access
        m_valid = 1'b1; m_addr = 32'h03000010; s_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("mid_rst_s_valid", s_valid, '0);
        check_val("mid_rst_m_ready", m_ready, 1'b0);
        check_val("mid_rst_err_count", err_count, 8'd0);
        check_val("mid_rst_err_addr", err_addr, 32'h0);
        rst = 1'b0;
        err_cnt_m  = 0;
        err_addr_m = 32'h0;
        @(negedge clk);
        run_txn(32'h00000040, 1);
        run_txn(32'h02000000, 0);
        idle_gap();
        check_val("final_err_count", err_count, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
